// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor. A WIDTH-bit add (or subtract)
// is performed CHUNK bits per clock, carrying between slices through a
// register, so the combinational carry chain is only CHUNK bits long.
// One operation is in flight at a time; valid/ready handshake on both sides.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  operands/mode presented
//   in_ready  block can accept an operation (IDLE and out of reset)
//   a, b      WIDTH-bit operands
//   c_in      carry-in for add (ignored when sub=1)
//   sub       0: a+b+c_in, 1: a-b computed as a+~b+1
//   out_valid result available (DONE)
//   out_ready downstream accepts the result
//   sum       result modulo 2^WIDTH
//   c_out     carry out of the MSB (subtract: 1 = no borrow)
//   ovf       signed overflow
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [CHUNK:0]   slice_sum;
  logic             accept;
  logic             last;

  // in_ready is gated by rst_n so it reads 0 for the whole reset interval
  // and rises together with the release of reset.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx == LAST);

  // The operand registers shift right one slice per RUN cycle, so the slice
  // being added is always in the low CHUNK bits and the final step sees the
  // operand MSBs at bit CHUNK-1.
  assign slice_sum = {1'b0, a_p0[CHUNK-1:0]} + {1'b0, b_p0[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Stage p0: operand capture (subtrahend inverted on entry) and per-slice shift
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= a;
      b_p0 <= sub ? ~b : b;
    end else if (state == RUN) begin
      a_p0 <= a_p0 >> CHUNK;
      b_p0 <= b_p0 >> CHUNK;
    end
  end

  // Slice index, inter-slice carry and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= '0;
            carry <= sub | c_in;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) sum[i*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
          end
          carry <= slice_sum[CHUNK];
          if (last) begin
            c_out <= slice_sum[CHUNK];
            ovf   <= (a_p0[CHUNK-1] == b_p0[CHUNK-1]) &&
                     (slice_sum[CHUNK-1] != a_p0[CHUNK-1]);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
